// File: rtl/alu_dw_sequencer_pkg.sv
// Shared constants for the double-word ALU sequencer.
// Opcodes, FSM state encoding and word width.
package alu_dw_sequencer_pkg;

  localparam int W = 16;

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_ADD2 = 3'b010;
  localparam logic [2:0] OP_SUB2 = 3'b011;
  localparam logic [2:0] OP_AND  = 3'b100;
  localparam logic [2:0] OP_OR   = 3'b101;
  localparam logic [2:0] OP_XOR  = 3'b110;
  localparam logic [2:0] OP_ROR  = 3'b111;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_LO   = 3'd1;
  localparam logic [2:0] ST_HI   = 3'd2;
  localparam logic [2:0] ST_FIX  = 3'd3;
  localparam logic [2:0] ST_DONE = 3'd4;

  function automatic logic is_arith(input logic [2:0] op);
    return ~op[2];
  endfunction

  function automatic logic is_ror(input logic [2:0] op);
    return op == OP_ROR;
  endfunction

endpackage

// File: rtl/alu_dw_sequencer.sv
// Sequences a 16-bit ALU over two or three passes
// to perform 32-bit ops; owns the C/Z flag register.
module alu_dw_sequencer
  import alu_dw_sequencer_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic [2:0]   req_op,
  input  logic [2*W-1:0] req_a,
  input  logic [2*W-1:0] req_b,
  output logic         resp_valid,
  input  logic         resp_ready,
  output logic [2*W-1:0] resp_data,
  output logic         resp_c,
  output logic         resp_z,
  output logic         flag_c,
  output logic         flag_z,
  output logic [2:0]   alu_op,
  output logic [W-1:0] alu_in1,
  output logic [W-1:0] alu_in2,
  output logic         alu_cin,
  input  logic [W-1:0] alu_out,
  input  logic         alu_c,
  input  logic         alu_z
);

  logic [2:0]     state;
  logic [2:0]     op_q;
  logic [2*W-1:0] a_q;
  logic [2*W-1:0] b_q;
  logic [W-1:0]   lo_q;
  logic [W-1:0]   hi_q;
  logic           k_q;
  logic           c1_q;

  logic           fin_en;
  logic [2*W-1:0] fin_data;
  logic           fin_c;
  logic           fin_z;

  localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

  assign req_ready  = (state == ST_IDLE);
  assign resp_valid = (state == ST_DONE);

  // Final pass: one word comes straight off the ALU, the other is captured.
  always_comb begin
    fin_en   = 1'b0;
    fin_data = {alu_out, lo_q};
    fin_c    = flag_c;
    fin_z    = alu_z & (lo_q == '0);
    unique case (1'b1)
      (state == ST_LO) && is_ror(op_q): begin
        fin_en   = 1'b1;
        fin_data = {hi_q, alu_out};
        fin_c    = alu_c;
        fin_z    = alu_z & (hi_q == '0);
      end
      (state == ST_HI) && !is_ror(op_q)
        && !(is_arith(op_q) && k_q): begin
        fin_en = 1'b1;
        fin_c  = is_arith(op_q) ? alu_c : flag_c;
      end
      (state == ST_FIX): begin
        fin_en = 1'b1;
        fin_c  = c1_q | alu_c;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      op_q      <= OP_ADD;
      a_q       <= '0;
      b_q       <= '0;
      lo_q      <= '0;
      hi_q      <= '0;
      k_q       <= 1'b0;
      c1_q      <= 1'b0;
      resp_data <= '0;
      resp_c    <= 1'b0;
      resp_z    <= 1'b0;
      flag_c    <= 1'b0;
      flag_z    <= 1'b0;
      alu_op    <= 3'b000;
      alu_in1   <= '0;
      alu_in2   <= '0;
      alu_cin   <= 1'b0;
    end else begin
      if (fin_en) begin
        resp_data <= fin_data;
        resp_c    <= fin_c;
        resp_z    <= fin_z;
        flag_c    <= fin_c;
        flag_z    <= fin_z;
        state     <= ST_DONE;
      end
      unique case (state)
        ST_IDLE: begin
          if (req_valid) begin
            op_q   <= req_op;
            a_q    <= req_a;
            b_q    <= req_b;
            alu_op <= req_op;
            if (is_ror(req_op)) begin
              alu_in1 <= req_a[2*W-1:W];
              alu_in2 <= '0;
              alu_cin <= flag_c;
              state   <= ST_HI;
            end else begin
              alu_in1 <= req_a[W-1:0];
              alu_in2 <= req_b[W-1:0];
              alu_cin <= 1'b0;
              state   <= ST_LO;
            end
          end
        end
        ST_LO: begin
          lo_q <= alu_out;
          if (!is_ror(op_q)) begin
            k_q     <= alu_c;
            alu_in1 <= a_q[2*W-1:W];
            alu_in2 <= b_q[2*W-1:W];
            alu_cin <= 1'b0;
            state   <= ST_HI;
          end
        end
        ST_HI: begin
          hi_q <= alu_out;
          c1_q <= alu_c;
          if (is_ror(op_q)) begin
            // Rotate-out of the high word feeds the low word.
            alu_in1 <= a_q[W-1:0];
            alu_cin <= alu_c;
            state   <= ST_LO;
          end else if (is_arith(op_q) && k_q) begin
            alu_in1 <= alu_out;
            alu_in2 <= ONE;
            alu_cin <= 1'b0;
            state   <= ST_FIX;
          end
        end
        ST_FIX: begin
          hi_q <= alu_out;
        end
        ST_DONE: begin
          if (resp_ready) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_dw_sequencer.sv
// Randomized self-checking bench for alu_dw_sequencer,
// with a behavioural 16-bit ALU and a 32-bit reference model.
module tb_alu_dw_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [2:0]  req_op = 3'b000;
  logic [31:0] req_a = '0;
  logic [31:0] req_b = '0;
  logic        resp_valid;
  logic        resp_ready = 1'b0;
  logic [31:0] resp_data;
  logic        resp_c;
  logic        resp_z;
  logic        flag_c;
  logic        flag_z;
  logic [2:0]  alu_op;
  logic [15:0] alu_in1;
  logic [15:0] alu_in2;
  logic        alu_cin;
  logic [15:0] alu_out;
  logic        alu_c;
  logic        alu_z;

  int checks = 0;
  int errors = 0;
  logic m_c = 1'b0;
  logic m_z = 1'b0;

  always #5 clk = ~clk;

  alu_dw_sequencer dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_a(req_a), .req_b(req_b),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_data(resp_data), .resp_c(resp_c), .resp_z(resp_z),
    .flag_c(flag_c), .flag_z(flag_z),
    .alu_op(alu_op), .alu_in1(alu_in1), .alu_in2(alu_in2),
    .alu_cin(alu_cin), .alu_out(alu_out),
    .alu_c(alu_c), .alu_z(alu_z)
  );

  // The existing 16-bit ALU, combinational.
  always_comb begin
    alu_out = '0;
    alu_c   = 1'b0;
    case (alu_op)
      3'b000, 3'b010: {alu_c, alu_out} = {1'b0, alu_in1} + {1'b0, alu_in2};
      3'b001, 3'b011: begin
        alu_out = alu_in1 - alu_in2;
        alu_c   = alu_in1 < alu_in2;
      end
      3'b100: alu_out = alu_in1 & alu_in2;
      3'b101: alu_out = alu_in1 | alu_in2;
      3'b110: alu_out = alu_in1 ^ alu_in2;
      default: begin
        alu_out = {alu_cin, alu_in1[15:1]};
        alu_c   = alu_in1[0];
      end
    endcase
    alu_z = (alu_out == '0);
  end

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic run(input logic [2:0] op, input logic [31:0] a,
                     input logic [31:0] b, input int hold);
    logic [32:0] s;
    logic [31:0] r;
    logic c;
    logic z;
    int lat_exp;
    int lat;
    int n;
    lat_exp = 2;
    r = '0;
    c = m_c;
    case (op)
      3'b000, 3'b010: begin
        s = {1'b0, a} + {1'b0, b};
        r = s[31:0];
        c = s[32];
        if (int'(a[15:0]) + int'(b[15:0]) > 65535) lat_exp = 3;
      end
      3'b001, 3'b011: begin
        r = a - b;
        c = a < b;
        if (a[15:0] < b[15:0]) lat_exp = 3;
      end
      3'b100: r = a & b;
      3'b101: r = a | b;
      3'b110: r = a ^ b;
      default: begin
        r = {m_c, a[31:1]};
        c = a[0];
      end
    endcase
    z = (r == 0);

    @(negedge clk);
    n = 0;
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("req_ready_idle", 64'(req_ready), 64'd1);
    req_op = op;
    req_a = a;
    req_b = b;
    req_valid = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_op = 3'($urandom);
    req_a = $urandom;
    req_b = $urandom;

    lat = 0;
    forever begin
      @(negedge clk);
      if (resp_valid || lat > 10) break;
      lat++;
    end
    check("latency", 64'(lat), 64'(lat_exp));
    check("resp_data", 64'(resp_data), 64'(r));
    check("resp_c", 64'(resp_c), 64'(c));
    check("resp_z", 64'(resp_z), 64'(z));
    check("flag_c", 64'(flag_c), 64'(c));
    check("flag_z", 64'(flag_z), 64'(z));
    check("req_ready_busy", 64'(req_ready), 64'd0);
    m_c = c;
    m_z = z;

    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check("hold_valid", 64'(resp_valid), 64'd1);
      check("hold_data", 64'(resp_data), 64'(r));
      check("hold_ready", 64'(req_ready), 64'd0);
    end

    resp_ready = 1'b1;
    @(posedge clk);
    #1;
    resp_ready = 1'b0;
    @(negedge clk);
    check("post_valid", 64'(resp_valid), 64'd0);
    check("post_ready", 64'(req_ready), 64'd1);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h0000_0000;
      1: return 32'hFFFF_FFFF;
      2: return {16'($urandom), 16'hFFFF};
      3: return {16'($urandom), 16'h0000};
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #3;
    check("rst_req_ready", 64'(req_ready), 64'd1);
    check("rst_resp_valid", 64'(resp_valid), 64'd0);
    check("rst_resp_data", 64'(resp_data), 64'd0);
    check("rst_resp_cz", 64'({resp_c, resp_z}), 64'd0);
    check("rst_flags", 64'({flag_c, flag_z}), 64'd0);
    check("rst_alu", 64'({alu_op, alu_in1, alu_in2, alu_cin}), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run(3'b000, 32'h0001_FFFF, 32'h0000_0001, 0);
    run(3'b000, 32'hFFFF_FFFF, 32'h0000_0001, 0);
    run(3'b010, 32'h1234_0000, 32'h0001_0001, 0);
    run(3'b001, 32'h0001_0000, 32'h0000_0001, 0);
    run(3'b011, 32'h0000_0000, 32'h0000_0001, 0);
    run(3'b111, 32'h0000_0003, 32'h1234_5678, 0);
    run(3'b111, 32'h0000_0000, 32'h0000_0000, 0);
    run(3'b001, 32'h0000_0000, 32'h0000_0001, 0);
    run(3'b110, 32'hA5A5_5A5A, 32'hA5A5_5A5A, 3);

    // Abort an ADD in its high pass; flags were set just before.
    run(3'b001, 32'h0000_0000, 32'h0000_0001, 0);
    @(negedge clk);
    req_op = 3'b000;
    req_a = 32'h0001_FFFF;
    req_b = 32'h0000_0001;
    req_valid = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_ready", 64'(req_ready), 64'd1);
    check("abort_valid", 64'(resp_valid), 64'd0);
    check("abort_flags", 64'({flag_c, flag_z}), 64'd0);
    check("abort_data", 64'(resp_data), 64'd0);
    m_c = 1'b0;
    m_z = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    run(3'b000, 32'h0001_FFFF, 32'h0000_0001, 0);

    for (int i = 0; i < 300; i++)
      run(3'($urandom), pick(), pick(), $urandom_range(0, 2));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_dw_sequencer.md
Name: alu_dw_sequencer

Overview:
Multi-cycle controller that performs 32-bit (double-word) operations by sequencing the existing 16-bit ALU over two or three passes. It chains carry/borrow between words, owns the architectural C/Z flag register and exposes a valid/ready request/response interface to the core. It sits between the decode/execute control and the 16-bit ALU instance and is the only driver of that ALU's inputs.

Parameters:
W, 16, ALU word width; double-word result is 2*W. Only 16 is supported.

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
req_valid  in  1  request present
req_ready  out  1  high only in IDLE
req_op  in  3  ALU opcode: 000/010 ADD, 001/011 SUB, 100 AND, 101 OR, 110 XOR, 111 ROR
req_a  in  2W  operand A
req_b  in  2W  operand B (ignored for ROR)
resp_valid  out  1  result valid, held until accepted
resp_ready  in  1  consumer accepts result
resp_data  out  2W  double-word result
resp_c  out  1  carry/borrow/rotate-out of this op
resp_z  out  1  1 when resp_data == 0
flag_c  out  1  architectural C flag
flag_z  out  1  architectural Z flag
alu_op  out  3  to ALU aluop
alu_in1  out  W  to ALU in1
alu_in2  out  W  to ALU in2
alu_cin  out  1  to ALU Cin
alu_out  in  W  from ALU aluout
alu_c  in  1  from ALU C
alu_z  in  1  from ALU Z

Behaviour:
- Reset (async, rst_n low): state IDLE; req_ready 1; resp_valid 0; resp_data 0; resp_c 0; resp_z 0; flag_c 0; flag_z 0; alu_op 000; alu_in1/alu_in2 0; alu_cin 0. Reset mid-operation aborts silently: no response, flags cleared.
- ALU treated as combinational within a cycle: ALU drives are registered and results sampled at the next rising edge.
- States: IDLE, LO, HI, FIX, DONE.
- IDLE: req_ready=1. On req_valid: latch op, A and B; go to the first pass (LO, or HI for ROR).
- ADD/SUB:
  - LO: drive op, A[15:0], B[15:0]; capture low result and k = alu_c (carry, or borrow for SUB) -> HI.
  - HI: drive op, A[31:16], B[31:16]; capture high result and c1 = alu_c. If k=1 -> FIX, else -> DONE with C=c1.
  - FIX: drive ADD (or SUB) with in1=high result, in2=1; replace the high result; C = c1 | alu_c -> DONE.
- AND/OR/XOR: LO then HI, no FIX; flag_c unchanged (resp_c reports the current flag_c).
- ROR (33-bit rotate through C):
  - HI: alu_cin = flag_c on A[31:16]; capture the high word and r = alu_c (A[16]).
  - LO: alu_cin = r on A[15:0]; capture the low word; C = alu_c (A[0]) -> DONE.
- Z = (low result == 0) & (high result == 0), computed from the captured words, not alu_z of a single pass.
- DONE: resp_valid=1; outputs stable while resp_ready=0. flag_c/flag_z update on the edge entering DONE. On resp_ready -> IDLE.
- Latency (acceptance edge to resp_valid high): 2 cycles normally, 3 with FIX. Throughput: next accept is the cycle after the response handshake; no overlap.
- req_valid outside IDLE is ignored; request operands are not re-sampled mid-operation.
- Arithmetic wraps mod 2^32. SUB C=1 means borrow, i.e. unsigned A<B. FIX never produces double-carry beyond 1.
- When not in LO/HI/FIX, ALU drives hold their last value (no toggling required).

Decomposition:
- Shared package: opcode constants (OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_ROR, plus aliases 010/011), state encoding, W.
- Single module, no sub-module. The bench instantiates the existing 16-bit ALU alongside it and wires alu_* ports.

Test Plan:
- ADD 0x0001_FFFF + 0x0000_0001 -> resp_data 0x0002_0000, C=0, Z=0, FIX taken, resp_valid 3 cycles after accept.
- ADD 0xFFFF_FFFF + 0x0000_0001 -> resp_data 0x0000_0000, C=1, Z=1; ADD 0x1234_0000 + 0x0001_0001 -> 0x1235_0001, no FIX, latency 2.
- SUB 0x0001_0000 - 0x0000_0001 -> 0x0000_FFFF, C=0; then SUB 0 - 1 -> 0xFFFF_FFFF, C=1, flag_c=1.
- With flag_c=1: ROR A=0x0000_0003 -> 0x8000_0001, C=1; next ROR A=0x0000_0000 -> 0x8000_0000, C=0.
- XOR A=B=0xA5A5_5A5A with flag_c=1 -> 0, Z=1, C stays 1; resp_ready held low 3 cycles -> resp_valid and data stable, req_ready stays 0.
- rst_n low during HI of an ADD -> immediately IDLE, resp_valid 0, flags 0; the next request completes correctly.
